// File: rtl/fsm_bin2bcd_seg.sv
// Four-digit multiplexed 7-segment driver: digit-scan FSM with per-frame
// input snapshot, followed by a combinational hex-to-segment decoder.
module fsm_bin2bcd_seg #(
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [15:0] in_4bcd,
  output logic [3:0]  out_bcd,
  output logic [3:0]  out_shr,
  output logic [6:0]  seg
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;

  state_t           state;
  logic [15:0]      snap;
  logic [DIV_W-1:0] div;
  logic             tick;

  assign tick = (div == DIV_LAST);

  // snap is reloaded only on the DIG3->DIG0 wrap so a frame never mixes values;
  // digit 0 takes its nibble straight from the input to show the fresh value.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state   <= DIG0;
      snap    <= '0;
      div     <= '0;
      out_bcd <= '0;
      out_shr <= 4'b0001;
    end else if (en) begin
      if (tick) begin
        div <= '0;
        case (state)
          DIG0: begin
            state   <= DIG1;
            out_bcd <= snap[7:4];
            out_shr <= 4'b0010;
          end
          DIG1: begin
            state   <= DIG2;
            out_bcd <= snap[11:8];
            out_shr <= 4'b0100;
          end
          DIG2: begin
            state   <= DIG3;
            out_bcd <= snap[15:12];
            out_shr <= 4'b1000;
          end
          default: begin
            state   <= DIG0;
            snap    <= in_4bcd;
            out_bcd <= in_4bcd[3:0];
            out_shr <= 4'b0001;
          end
        endcase
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  always_comb begin
    seg = '0;
    case (out_bcd)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
      default: seg = '0;
    endcase
  end

endmodule

// File: tb/tb_fsm_bin2bcd_seg.sv
// Directed self-checking bench for fsm_bin2bcd_seg (SCAN_DIV=1 and SCAN_DIV=3 instances).
module tb_fsm_bin2bcd_seg;

  logic        clk = 1'b0;
  logic        resetn, en;
  logic [15:0] in_4bcd;
  logic [3:0]  out_bcd, out_shr;
  logic [6:0]  seg;

  logic        resetn3, en3;
  logic [15:0] in3;
  logic [3:0]  bcd3, shr3;
  logic [6:0]  seg3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_bin2bcd_seg #(.SCAN_DIV(1)) dut (
    .clk(clk), .resetn(resetn), .en(en), .in_4bcd(in_4bcd),
    .out_bcd(out_bcd), .out_shr(out_shr), .seg(seg)
  );

  fsm_bin2bcd_seg #(.SCAN_DIV(3)) dut3 (
    .clk(clk), .resetn(resetn3), .en(en3), .in_4bcd(in3),
    .out_bcd(bcd3), .out_shr(shr3), .seg(seg3)
  );

  // Segment patterns (gfedcba) for hex digits 0..F.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
          7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
          7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
          7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    return t[n];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] v);
    resetn  = 1'b1;
    en      = 1'b1;
    in_4bcd = v;
    step();
    step();
    resetn = 1'b0;
  endtask

  task automatic test_reset();
    resetn3 = 1'b1; en3 = 1'b1; in3 = 16'h5678;
    do_reset(16'h1234);
    checks++;
    if ({out_shr, out_bcd, seg} !== {4'b0001, 4'h0, 7'b0111111}) begin
      errors++;
      $display("FAIL reset: shr/bcd/seg got %b/%h/%b exp 0001/0/0111111", out_shr, out_bcd, seg);
    end
    checks++;
    if ({shr3, bcd3, seg3} !== {4'b0001, 4'h0, 7'b0111111}) begin
      errors++;
      $display("FAIL reset_div3: shr/bcd/seg got %b/%h/%b exp 0001/0/0111111", shr3, bcd3, seg3);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_shr [8];
    logic [3:0] exp_bcd [8];
    exp_shr = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_bcd = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h3, 4'h2, 4'h1, 4'h4};
    do_reset(16'h1234);
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({out_shr, out_bcd, seg} !== {exp_shr[i], exp_bcd[i], seg_of(exp_bcd[i])}) begin
        errors++;
        $display("FAIL scan[%0d]: shr/bcd/seg got %b/%h/%b exp %b/%h/%b", i,
                 out_shr, out_bcd, seg, exp_shr[i], exp_bcd[i], seg_of(exp_bcd[i]));
      end
    end
    checks++;
    if (seg !== 7'b1100110) begin
      errors++;
      $display("FAIL scan_seg4: seg got %b exp 1100110", seg);
    end
  endtask

  task automatic test_frames();
    logic [15:0] prev, frame_val;
    logic [3:0]  nib;
    int k;
    frame_val = '0;
    k = 0;
    do_reset(16'd4660);
    for (int v = 4660; v <= 4999; v++) begin
      for (int c = 0; c < 10; c++) begin
        if (c == 0) in_4bcd = 16'(v);
        prev = in_4bcd;
        step();
        k = (k + 1) % 4;
        if (k == 0) frame_val = prev;
        nib = frame_val[4*k +: 4];
        checks++;
        if ({out_shr, out_bcd, seg} !== {4'(1 << k), nib, seg_of(nib)}) begin
          errors++;
          $display("FAIL frame v=%h: shr/bcd/seg got %b/%h/%b exp %b/%h/%b", frame_val,
                   out_shr, out_bcd, seg, 4'(1 << k), nib, seg_of(nib));
        end
        if (frame_val == 16'h123A && k == 0) begin
          checks++;
          if (seg !== 7'b1110111) begin
            errors++;
            $display("FAIL frame_hexA: seg got %b exp 1110111", seg);
          end
        end
      end
    end
  endtask

  task automatic test_decoder();
    logic [15:0] vals [4];
    logic [3:0]  nib;
    vals = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
    do_reset(16'h0000);
    step(); step(); step();
    foreach (vals[j]) begin
      in_4bcd = vals[j];
      for (int d = 0; d < 4; d++) begin
        step();
        nib = vals[j][4*d +: 4];
        checks++;
        if ({out_shr, out_bcd, seg} !== {4'(1 << d), nib, seg_of(nib)}) begin
          errors++;
          $display("FAIL decode %h: shr/bcd/seg got %b/%h/%b exp %b/%h/%b", nib,
                   out_shr, out_bcd, seg, 4'(1 << d), nib, seg_of(nib));
        end
      end
    end
  endtask

  task automatic test_hold_en();
    do_reset(16'h1234);
    for (int i = 0; i < 5; i++) step();
    en = 1'b0;
    in_4bcd = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({out_shr, out_bcd, seg} !== {4'b0010, 4'h3, 7'b1001111}) begin
        errors++;
        $display("FAIL hold[%0d]: shr/bcd/seg got %b/%h/%b exp 0010/3/1001111", i, out_shr, out_bcd, seg);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if ({out_shr, out_bcd} !== {4'b0100, 4'h2}) begin
      errors++;
      $display("FAIL resume: shr/bcd got %b/%h exp 0100/2", out_shr, out_bcd);
    end
    step();
    checks++;
    if ({out_shr, out_bcd} !== {4'b1000, 4'h1}) begin
      errors++;
      $display("FAIL resume2: shr/bcd got %b/%h exp 1000/1", out_shr, out_bcd);
    end
  endtask

  task automatic test_scan_div3();
    logic [3:0] eb;
    resetn3 = 1'b1; en3 = 1'b1; in3 = 16'h5678;
    step(); step();
    resetn3 = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      eb = (n == 12) ? 4'h8 : 4'h0;
      checks++;
      if ({shr3, bcd3, seg3} !== {4'(1 << ((n / 3) % 4)), eb, seg_of(eb)}) begin
        errors++;
        $display("FAIL div3[%0d]: shr/bcd/seg got %b/%h/%b exp %b/%h/%b", n,
                 shr3, bcd3, seg3, 4'(1 << ((n / 3) % 4)), eb, seg_of(eb));
      end
    end
    step();
    en3 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if ({shr3, bcd3} !== {4'b0001, 4'h8}) begin
      errors++;
      $display("FAIL div3_hold: shr/bcd got %b/%h exp 0001/8", shr3, bcd3);
    end
    en3 = 1'b1;
    step();
    checks++;
    if (shr3 !== 4'b0001) begin
      errors++;
      $display("FAIL div3_stretch: shr got %b exp 0001", shr3);
    end
    step();
    checks++;
    if ({shr3, bcd3, seg3} !== {4'b0010, 4'h7, 7'b0000111}) begin
      errors++;
      $display("FAIL div3_adv: shr/bcd/seg got %b/%h/%b exp 0010/7/0000111", shr3, bcd3, seg3);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(16'h1234);
    for (int i = 0; i < 6; i++) step();
    checks++;
    if ({out_shr, out_bcd} !== {4'b0100, 4'h2}) begin
      errors++;
      $display("FAIL pre_rst: shr/bcd got %b/%h exp 0100/2", out_shr, out_bcd);
    end
    resetn = 1'b1;
    en = 1'b0;
    step();
    checks++;
    if ({out_shr, out_bcd, seg} !== {4'b0001, 4'h0, 7'b0111111}) begin
      errors++;
      $display("FAIL mid_rst: shr/bcd/seg got %b/%h/%b exp 0001/0/0111111", out_shr, out_bcd, seg);
    end
    resetn = 1'b0;
    en = 1'b1;
    step();
    checks++;
    if ({out_shr, out_bcd} !== {4'b0010, 4'h0}) begin
      errors++;
      $display("FAIL snap_clr1: shr/bcd got %b/%h exp 0010/0", out_shr, out_bcd);
    end
    step();
    checks++;
    if ({out_shr, out_bcd} !== {4'b0100, 4'h0}) begin
      errors++;
      $display("FAIL snap_clr2: shr/bcd got %b/%h exp 0100/0", out_shr, out_bcd);
    end
  endtask

  initial begin
    resetn = 1'b1; en = 1'b0; in_4bcd = '0;
    resetn3 = 1'b1; en3 = 1'b0; in3 = '0;
    test_reset();
    test_scan();
    test_frames();
    test_decoder();
    test_hold_en();
    test_scan_div3();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_bin2bcd_seg.md
# fsm_bin2bcd_seg

Four-digit multiplexed 7-segment display driver for the calculator front panel. It scans a packed 16-bit, four-nibble BCD/hex value one digit at a time. For each digit it emits the digit code, a one-hot digit-enable, and the decoded segment pattern. Internally it is the digit-scan FSM (`fsm_bin_2bcd`) feeding a combinational nibble-to-segment decoder (`bcd_2seg`).

## Interface
- `SCAN_DIV`, default 1: number of enabled clock cycles per digit step (≥1).
- `clk` input 1: system clock; all state updates on its rising edge.
- `resetn` input 1: synchronous, active-high reset. The port keeps the codebase name; asserting it (1) resets the block.
- `en` input 1: scan enable; when 0, all state holds.
- `in_4bcd` input 16: packed value; nibble k = `in_4bcd[4k+3:4k]`; digit 0 is the least significant.
- `out_bcd` output 4: nibble of the currently selected digit (registered).
- `out_shr` output 4: one-hot digit enable; bit k set = digit k active (registered).
- `seg` output 7: segment pattern for `out_bcd`, active-high, bit0=a … bit6=g (combinational).

## Operation
- Registers:
  - FSM state: DIG0, DIG1, DIG2, DIG3.
  - 16-bit snapshot `snap`.
  - Divider counter `div`, range 0..SCAN_DIV-1.
  - `out_bcd`, `out_shr`.
- Reset (`resetn`=1 at an edge): state=DIG0, snap=0, div=0, `out_bcd`=0, `out_shr`=4'b0001. Reset has priority over `en`.
- Tick: an edge with `en`=1 and div==SCAN_DIV-1. At a tick, div wraps to 0. On other enabled edges, div increments.
- On a tick, the state advances DIG0→DIG1→DIG2→DIG3→DIG0.
  - Leaving DIG3: snap<=`in_4bcd` and `out_bcd`<=`in_4bcd[3:0]`, so digit 0 uses the fresh value.
  - Other transitions: `out_bcd`<=snap nibble of the next state.
- `out_shr` always equals the one-hot of the current state: rotate-left on each tick, 1000→0001 on wrap.
- `en`=0: state, div, snap, `out_bcd` and `out_shr` all hold.
- `in_4bcd` is sampled only at the DIG3→DIG0 tick. A frame never mixes two input values. Changes between wraps appear at the next frame.
- Decoder, full hex (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- The decoder is purely combinational with no X for any 4-bit input.

## Timing
- `seg` follows `out_bcd` in the same cycle, with zero added latency.
- With SCAN_DIV=1 and `en`=1: one digit per clock, a frame every 4 clocks.
- Input-to-display latency: a new `in_4bcd` shows on digit 0 at the next DIG3→DIG0 tick, then digits 1..3 on the following 3 ticks. Worst case is 4 ticks plus 3 ticks to finish the frame.
- Reset mid-scan: the next cycle shows DIG0, `out_shr`=0001, `out_bcd`=0, `seg`=0111111. The first post-reset frame displays zeros on digits 1–3, because snap=0 until the first wrap.
- `out_shr` is never all-zero and never has more than one bit set, including during and after reset.
- SCAN_DIV=1: div is constant 0 and every enabled edge is a tick.

## Test plan
- Reset for 2 cycles, release with `in_4bcd`=16'h1234, `en`=1, SCAN_DIV=1:
  - Cycles 1–3: `out_shr`=0010/0100/1000 with `out_bcd`=0.
  - Cycle 4: 0001/4, `seg`=1100110.
  - Then 0010/3, 0100/2, 1000/1, repeating.
- Drive 4660..4999 (16'h1234..16'h1387), changing every 10 clocks:
  - Each displayed frame matches a single snapshot value.
  - Hex nibbles decode, e.g. 16'h123A gives digit 0 `seg`=1110111.
- Decoder sweep: force `out_bcd` 0..F through frames using `in_4bcd`=16'hFEDC, 16'hBA98, 16'h7654, 16'h3210; check all 16 patterns.
- Toggle `en` low for 5 cycles mid-frame: all outputs hold; scanning resumes at the next digit.
- SCAN_DIV=3: each digit is held exactly 3 enabled cycles; de-asserting `en` stretches the hold accordingly.
- Assert reset while in DIG2: the next cycle gives `out_shr`=0001, `out_bcd`=0, and the snapshot is cleared.
